// File: rtl/irig_event_stamper.sv
// irig_event_stamper
//   Extends the IRIG-B decoded 1 s time with a sub-second tick counter that is
//   realigned on every PPS rising edge, and captures a full timestamp into a
//   first-word-fall-through FIFO on each rising edge of an asynchronous event.
//
// Ports
//   clk                 system clock (TICKS_PER_SEC ticks per second)
//   rst                 synchronous reset, active low
//   pps                 PPS from the decoder, synchronous to clk
//   ts_year/day/sec_day decoded time, valid by the cycle pps rises
//   event_in            asynchronous event strobe
//   evt_valid/evt_ready FIFO head handshake (pop on valid & ready)
//   evt_year/day/sec_day/subsec/locked   FIFO head contents
//   locked              PPS lock status
//   overflow            sticky: an event was dropped on a full FIFO
//   fifo_count          FIFO occupancy
//
// Build option
//   IRIG_HOLDOVER_EN    when defined, lock loss enters holdover: the counter
//                       wraps every second and the shadow time free-runs,
//                       instead of saturating with the time frozen.
module irig_event_stamper #(
  parameter int TICKS_PER_SEC = 10000000,
  parameter int PPS_TOL       = 1000,
  parameter int SUBSEC_W      = 24,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pps,
  input  logic [6:0]                    ts_year,
  input  logic [8:0]                    ts_day,
  input  logic [16:0]                   ts_sec_day,
  input  logic                          event_in,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [6:0]                    evt_year,
  output logic [8:0]                    evt_day,
  output logic [16:0]                   evt_sec_day,
  output logic [SUBSEC_W-1:0]           evt_subsec,
  output logic                          evt_locked,
  output logic                          locked,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [SUBSEC_W-1:0] SUB_MAX  = SUBSEC_W'(TICKS_PER_SEC - 1 + PPS_TOL);
  localparam logic [SUBSEC_W-1:0] SUB_LAST = SUBSEC_W'(TICKS_PER_SEC - 1);

  typedef struct packed {
    logic                lk;
    logic [6:0]          yr;
    logic [8:0]          day;
    logic [16:0]         sec;
    logic [SUBSEC_W-1:0] sub;
  } stamp_t;

  // ---------------- time base ----------------
  logic                pps_d_q, pps_rise;
  logic [SUBSEC_W-1:0] subsec_q, subsec_d;
  logic                locked_q, locked_d;
  logic [6:0]          yr_q, yr_d;
  logic [8:0]          day_q, day_d;
  logic [16:0]         sec_q, sec_d;
`ifdef IRIG_HOLDOVER_EN
  localparam logic [SUBSEC_W-1:0] SUB_TOL = SUBSEC_W'(PPS_TOL);
  logic hold_q, hold_d, adv;
`endif

  assign pps_rise = pps & ~pps_d_q;

  always_comb begin
    subsec_d = subsec_q;
    locked_d = locked_q;
    yr_d     = yr_q;
    day_d    = day_q;
    sec_d    = sec_q;
`ifdef IRIG_HOLDOVER_EN
    hold_d   = hold_q;
    adv      = 1'b0;
`endif
    if (pps_rise) begin
      // Every PPS realigns, early or late.
      yr_d     = ts_year;
      day_d    = ts_day;
      sec_d    = ts_sec_day;
      subsec_d = '0;
      locked_d = 1'b1;
`ifdef IRIG_HOLDOVER_EN
      hold_d   = 1'b0;
    end else if (hold_q && subsec_q == SUB_LAST) begin
      subsec_d = '0;
      adv      = 1'b1;
`endif
    end else if (subsec_q == SUB_MAX) begin
      locked_d = 1'b0;
`ifdef IRIG_HOLDOVER_EN
      // Only a previously locked time base free-runs; before the first PPS
      // there is no time to carry forward, so the counter just saturates.
      if (locked_q) begin
        subsec_d = SUB_TOL;
        hold_d   = 1'b1;
        adv      = 1'b1;
      end
`endif
    end else begin
      subsec_d = subsec_q + 1'b1;
    end
`ifdef IRIG_HOLDOVER_EN
    if (adv) begin
      if (sec_q >= 17'd86399) begin
        sec_d = '0;
        if (day_q >= ((yr_q[1:0] == 2'd0) ? 9'd366 : 9'd365)) begin
          day_d = 9'd1;
          yr_d  = (yr_q >= 7'd99) ? 7'd0 : yr_q + 1'b1;
        end else begin
          day_d = day_q + 1'b1;
        end
      end else begin
        sec_d = sec_q + 1'b1;
      end
    end
`endif
  end

  // ---------------- event synchronizer ----------------
  logic sync1_q, sync2_q, sync3_q, evt_edge;
  assign evt_edge = sync2_q & ~sync3_q;

  // Stamp from the values present this cycle; a coincident PPS wins so the
  // event lands at the start of the new second.
  stamp_t stamp;
  always_comb begin
    stamp.lk  = pps_rise | locked_q;
    stamp.yr  = pps_rise ? ts_year    : yr_q;
    stamp.day = pps_rise ? ts_day     : day_q;
    stamp.sec = pps_rise ? ts_sec_day : sec_q;
    stamp.sub = pps_rise ? '0 : ((subsec_q > SUB_LAST) ? SUB_LAST : subsec_q);
  end

  // ---------------- FIFO ----------------
  stamp_t          mem_q [FIFO_DEPTH];
  stamp_t          head, last_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, full, pop, push;

  assign full = (cnt_q == CW'(FIFO_DEPTH));
  assign pop  = (cnt_q != '0) & evt_ready;
  assign push = evt_edge & (~full | pop);
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= stamp;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pps_d_q  <= 1'b0;
      subsec_q <= '0;
      locked_q <= 1'b0;
      yr_q     <= '0;
      day_q    <= '0;
      sec_q    <= '0;
`ifdef IRIG_HOLDOVER_EN
      hold_q   <= 1'b0;
`endif
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sync3_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      last_q   <= '0;
    end else begin
      pps_d_q  <= pps;
      subsec_q <= subsec_d;
      locked_q <= locked_d;
      yr_q     <= yr_d;
      day_q    <= day_d;
      sec_q    <= sec_d;
`ifdef IRIG_HOLDOVER_EN
      hold_q   <= hold_d;
`endif
      sync1_q  <= event_in;
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q    <= cnt_d;
      if (evt_edge & full & ~pop) ovf_q <= 1'b1;
      // Remember what was last shown so an empty FIFO keeps presenting it.
      if (cnt_q != '0) last_q <= head;
    end
  end

  stamp_t shown;
  assign shown       = (cnt_q != '0) ? head : last_q;
  assign evt_valid   = (cnt_q != '0);
  assign evt_year    = shown.yr;
  assign evt_day     = shown.day;
  assign evt_sec_day = shown.sec;
  assign evt_subsec  = shown.sub;
  assign evt_locked  = shown.lk;
  assign locked      = locked_q;
  assign overflow    = ovf_q;
  assign fifo_count  = cnt_q;

endmodule
